mem_port_arbiter: RTL and testbench

Shares one single-port memory between the fetch stage (read-only instruction port) and the MEM stage (load/store data port) of the pipelined core. Data requests win by default, since they belong to the older instruction. A bounded-burst counter keeps instruction fetch from starving. One transaction is outstanding at a time, and each response is routed back to the port that issued it.

---
 rtl/xgriscv_defines.sv | 15 +
 rtl/mem_arb_sel.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_defines.sv
// Shared core definitions: memory-port arbiter state encodings and port-owner tags.
package xgriscv_defines;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Owner selection for the shared memory port: data-first priority, anti-starvation
// burst counter for fetch, and a lock that pins the owner while the memory stalls.
module mem_arb_sel
  import xgriscv_defines::*;
#(
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       m_req,
  input  logic       m_gnt,
  output arb_owner_e owner
);

  localparam int unsigned   CW       = $clog2(D_BURST_MAX + 1);
  localparam logic [CW-1:0] DCNT_MAX = CW'(D_BURST_MAX);

  logic [CW-1:0] dcnt_q;
  logic          lock_q;
  arb_owner_e    sel_q;
  arb_owner_e    pick;
  logic          grant;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick = OWNER_D;
    if (i_req && (!d_req || dcnt_q == DCNT_MAX)) pick = OWNER_I;
  end

  // A stalled request keeps its owner so its fields stay stable until accepted.
  assign owner = lock_q ? sel_q : pick;
  assign grant = m_req & m_gnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt_q <= '0;
      lock_q <= 1'b0;
      sel_q  <= OWNER_I;
    end else begin
      if (m_req && !m_gnt) begin
        lock_q <= 1'b1;
        sel_q  <= owner;
      end else begin
        lock_q <= 1'b0;
      end

      if (grant) begin
        if (owner == OWNER_D && i_req) begin
          if (dcnt_q != DCNT_MAX) dcnt_q <= dcnt_q + CW'(1);
        end else begin
          dcnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port,
// one transaction outstanding, responses routed back to the issuing port.
module mem_port_arbiter
  import xgriscv_defines::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  arb_state_e state_q, state_d;
  arb_owner_e owner;
  logic       idle;

  assign idle  = (state_q == ARB_IDLE);
  assign busy  = !idle;
  assign m_req = idle & (i_req | d_req);

  mem_arb_sel #(
    .D_BURST_MAX (D_BURST_MAX)
  ) u_sel (
    .clk   (clk),
    .reset (reset),
    .i_req (i_req),
    .d_req (d_req),
    .m_req (m_req),
    .m_gnt (m_gnt),
    .owner (owner)
  );

  // Fetch is always a full-word read.
  always_comb begin
    m_addr  = d_addr;
    m_we    = d_we;
    m_be    = d_be;
    m_wdata = d_wdata;
    if (owner == OWNER_I) begin
      m_addr = i_addr;
      m_we   = 1'b0;
      m_be   = '1;
    end
  end

  assign i_gnt = m_req & m_gnt & (owner == OWNER_I);
  assign d_gnt = m_req & m_gnt & (owner == OWNER_D);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_gnt)      state_d = ARB_WAIT_I;
        else if (d_gnt) state_d = ARB_WAIT_D;
      end
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (m_rvalid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Responses only count while waiting; m_rvalid in IDLE is dropped.
  assign i_rvalid = (state_q == ARB_WAIT_I) & m_rvalid;
  assign d_rvalid = (state_q == ARB_WAIT_D) & m_rvalid;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural arbitration model checks every
// cycle, and a response scoreboard checks routing and data of each completed transaction.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_gnt, m_rvalid, busy;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .D_BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        to_i;
    logic        has_data;
    logic [31:0] data;
  } rsp_t;

  rsp_t  sb[$];
  rsp_t  mon_r;
  int    checks = 0;
  int    errors = 0;
  string gnt_seq;

  // Two memory images: one updated from the issued stimulus, one from what the DUT sends.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rsp_mem [logic [31:0]];

  // Behavioural arbitration state: outstanding owner, stalled owner, data streak length.
  bit mdl_busy, mdl_to_i, mdl_locked, mdl_lock_i;
  int mdl_streak;
  bit i_hs, d_hs;

  int          gnt_pct = 100, lat_min = 2, lat_max = 2, stray_pct = 0;
  bit          rsp_pend = 1'b0;
  int          rsp_cnt;
  logic [31:0] rsp_data;
  bit          auto_masters = 1'b0;
  int          i_pct = 0, d_pct = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rsp_rd(input logic [31:0] a);
    return rsp_mem.exists(a) ? rsp_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(63)) << 2;
  endfunction

  // Called at the falling edge: compare against the model, then advance it past the next rising edge.
  task automatic model_check();
    bit   mreq_e, own_i, ig_e, dg_e;
    rsp_t r;
    i_hs = i_req && i_gnt;
    d_hs = d_req && d_gnt;
    if (i_gnt) gnt_seq = {gnt_seq, "I"};
    if (d_gnt) gnt_seq = {gnt_seq, "D"};
    if (!reset) begin
      check("rst_busy", busy, 0);
      check("rst_m_req", m_req, 0);
      check("rst_gnt", {i_gnt, d_gnt}, 0);
      check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      mdl_busy = 0; mdl_locked = 0; mdl_streak = 0;
      sb.delete();
      return;
    end
    mreq_e = !mdl_busy && (i_req || d_req);
    own_i  = mdl_locked ? mdl_lock_i : (i_req && (!d_req || mdl_streak == BM));
    ig_e   = mreq_e && m_gnt && own_i;
    dg_e   = mreq_e && m_gnt && !own_i;
    check("busy", busy, mdl_busy);
    check("m_req", m_req, mreq_e);
    check("i_gnt", i_gnt, ig_e);
    check("d_gnt", d_gnt, dg_e);
    check("i_rvalid", i_rvalid, mdl_busy && mdl_to_i && m_rvalid);
    check("d_rvalid", d_rvalid, mdl_busy && !mdl_to_i && m_rvalid);
    if (mreq_e) begin
      check("m_addr", m_addr, own_i ? i_addr : d_addr);
      check("m_we", m_we, own_i ? 1'b0 : d_we);
      check("m_be", m_be, own_i ? 4'hF : d_be);
      if (!own_i && d_we) check("m_wdata", m_wdata, d_wdata);
    end

    // Memory responder acts on what the DUT actually presented.
    if (m_req && m_gnt) begin
      rsp_pend = 1'b1;
      rsp_cnt  = $urandom_range(lat_max, lat_min);
      if (m_we) begin
        rsp_mem[m_addr] = merge(rsp_rd(m_addr), m_wdata, m_be);
        rsp_data = $urandom;
      end else begin
        rsp_data = rsp_rd(m_addr);
      end
    end

    if (mdl_busy && m_rvalid) mdl_busy = 0;
    if (mreq_e) begin
      if (m_gnt) begin
        mdl_busy = 1; mdl_to_i = own_i; mdl_locked = 0;
        if (own_i) begin
          mdl_streak = 0;
          r = '{1'b1, 1'b1, ref_rd(i_addr)};
        end else begin
          mdl_streak = i_req ? ((mdl_streak < BM) ? mdl_streak + 1 : BM) : 0;
          if (d_we) begin
            ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_be);
            r = '{1'b0, 1'b0, 32'h0};
          end else begin
            r = '{1'b0, 1'b1, ref_rd(d_addr)};
          end
        end
        sb.push_back(r);
      end else begin
        mdl_locked = 1; mdl_lock_i = own_i;
      end
    end
  endtask

  task automatic drive_memory();
    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    m_gnt    = ($urandom_range(99) < gnt_pct);
    if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = rsp_data;
        rsp_pend = 1'b0;
      end
    end else if ($urandom_range(99) < stray_pct) begin
      m_rvalid = 1'b1;
    end
  endtask

  task automatic drive_masters();
    if (!i_req || i_hs) begin
      i_req  = ($urandom_range(99) < i_pct);
      i_addr = rand_addr();
    end
    if (!d_req || d_hs) begin
      d_req   = ($urandom_range(99) < d_pct);
      d_we    = 1'($urandom_range(1));
      d_be    = 4'($urandom_range(15, 1));
      d_addr  = rand_addr();
      d_wdata = $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    drive_memory();
    if (auto_masters) drive_masters();
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; rsp_pend = 0; m_rvalid = 0;
    reset = 0;
    step();
    reset = 1;
  endtask

  // Response scoreboard: each presented response must match the oldest granted transaction.
  always @(negedge clk) begin
    if (reset && (i_rvalid || d_rvalid)) begin
      check("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_r = sb.pop_front();
        check("rsp_port", {i_rvalid, d_rvalid}, mon_r.to_i ? 2'b10 : 2'b01);
        if (mon_r.has_data && mon_r.to_i)  check("i_rdata", i_rdata, mon_r.data);
        if (mon_r.has_data && !mon_r.to_i) check("d_rdata", d_rdata, mon_r.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    gnt_seq = "";
    repeat (2) step();
    reset = 1;

    // Fetch only, response two cycles after the grant.
    ref_mem[32'h100] = 32'h13; rsp_mem[32'h100] = 32'h13;
    i_req = 1; i_addr = 32'h100; m_gnt = 1;
    #1 check("fetch_i_gnt", i_gnt, 1);
    step(); i_req = 0;
    #1 check("fetch_gap_rvalid", i_rvalid, 0);
    step();
    #1;
    check("fetch_i_rvalid", i_rvalid, 1);
    check("fetch_i_rdata", i_rdata, 32'h13);
    check("fetch_d_rvalid", d_rvalid, 0);
    step();

    // Simultaneous requests with an empty streak: the store wins.
    do_reset();
    lat_min = 1; lat_max = 1; gnt_pct = 100; m_gnt = 1;
    i_req = 1; i_addr = 32'h40;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hCAFE_BABE;
    #1;
    check("both_m_we", m_we, 1);
    check("both_m_be", m_be, 4'b0011);
    check("both_m_addr", m_addr, 32'h2000);
    check("both_d_gnt", d_gnt, 1);
    check("both_i_gnt", i_gnt, 0);
    step(); d_req = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (i_hs) i_req = 0;
    end

    // Both ports saturated: fetch gets through once per burst.
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1; stray_pct = 0;
    gnt_seq = ""; i_pct = 100; d_pct = 100; auto_masters = 1;
    drive_masters();
    for (int c = 0; c < 60 && gnt_seq.len() < 10; c++) step();
    checks++;
    if (gnt_seq.substr(0, 9) != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL burst_seq actual=%s expected=DDDDIDDDDI", gnt_seq);
    end
    auto_masters = 0;

    // Reset while a load is outstanding; the late response must be ignored.
    do_reset();
    lat_min = 3; lat_max = 3; gnt_pct = 100; m_gnt = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
    #1 check("rstmid_d_gnt", d_gnt, 1);
    step(); d_req = 0; reset = 0;
    #1 check("rstmid_busy", busy, 0);
    step(); reset = 1;
    step();
    #1;
    check("rstmid_rvalid_seen", m_rvalid, 1);
    check("rstmid_d_rvalid", d_rvalid, 0);
    check("rstmid_busy_after", busy, 0);
    step();

    // Stalled fetch keeps ownership while a load arrives.
    do_reset();
    lat_min = 1; lat_max = 1; gnt_pct = 0; m_gnt = 0;
    i_req = 1; i_addr = 32'h180;
    #1 check("lock_m_addr0", m_addr, 32'h180);
    step(); d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h280;
    #1;
    check("lock_m_addr1", m_addr, 32'h180);
    check("lock_d_gnt1", d_gnt, 0);
    step();
    #1 check("lock_m_addr2", m_addr, 32'h180);
    gnt_pct = 100;
    step();
    #1;
    check("lock_i_gnt", i_gnt, 1);
    check("lock_d_wait", d_gnt, 0);
    step(); i_req = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (d_hs) d_req = 0;
    end

    // Stray memory response while idle.
    m_rvalid = 1;
    #1;
    check("stray_i_rvalid", i_rvalid, 0);
    check("stray_d_rvalid", d_rvalid, 0);
    check("stray_busy", busy, 0);
    step();

    // Randomized traffic with memory stalls, variable latency and stray responses.
    do_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 3; stray_pct = 10;
    i_pct = 60; d_pct = 60; auto_masters = 1;
    drive_masters();
    repeat (3000) step();
    i_pct = 0; d_pct = 0; stray_pct = 0; gnt_pct = 100;
    repeat (20) step();
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
